// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state type shared by multicycle_alu and alu_iter_unit
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_DIVU = 4'b1010;
  localparam logic [3:0] ALU_REMU = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shift-add MUL and restoring DIVU/REMU, one bit per cycle for DATA_WIDTH cycles
module alu_iter_unit import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] x, y, z, x_n, y_n, z_n;
  logic [DATA_WIDTH:0] t, d;
  logic [CW-1:0] cnt;
  logic [3:0] op_r;
  logic busy, is_mul, ge;
  assign is_mul = op_r == ALU_MUL;
  assign done = busy && cnt == CW'(DATA_WIDTH - 1);
  // one iteration step; result is the post-step value so the top can latch it on the final cycle
  always_comb begin
    t = {z, x[DATA_WIDTH-1]};
    d = t - {1'b0, y};
    ge = !d[DATA_WIDTH];
    x_n = is_mul ? x << 1 : {x[DATA_WIDTH-2:0], ge};
    y_n = is_mul ? y >> 1 : y;
    z_n = is_mul ? z + (y[0] ? x : '0) : (ge ? d[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0]);
    result = op_r == ALU_DIVU ? x_n : z_n;
  end
  // operand load on start, then step until the counter reaches DATA_WIDTH-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_r <= '0;
      x    <= '0;
      y    <= '0;
      z    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      op_r <= op;
      x    <= a;
      y    <= b;
      z    <= '0;
    end else if (busy) begin
      busy <= !done;
      cnt  <= done ? '0 : cnt + 1'b1;
      x    <= x_n;
      y    <= y_n;
      z    <= z_n;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with single-cycle ops; MUL/DIVU/REMU only when ALU_MULDIV_EN is defined
module multicycle_alu import alu_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam int SW = $clog2(DATA_WIDTH);
  state_t state, next;
  logic [3:0] op;
  logic [SW-1:0] sh;
  logic [DATA_WIDTH-1:0] sc, it_result;
  logic accept, is_iter, it_done;
  assign op = 4'(Operation);
  assign sh = SrcB[SW-1:0];
  assign in_ready = state == IDLE && !reset;
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
`ifdef ALU_MULDIV_EN
  assign is_iter = op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
  alu_iter_unit #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_iter),
    .op     (op),
    .a      (SrcA),
    .b      (SrcB),
    .done   (it_done),
    .result (it_result)
  );
`else
  assign is_iter = 1'b0;
  assign it_done = 1'b0;
  assign it_result = '0;
`endif
  // single-cycle datapath; undefined and disabled opcodes yield zero
  always_comb begin
    case (op)
      ALU_AND:  sc = SrcA & SrcB;
      ALU_OR:   sc = SrcA | SrcB;
      ALU_ADD:  sc = SrcA + SrcB;
      ALU_XOR:  sc = SrcA ^ SrcB;
      ALU_SLL:  sc = SrcA << sh;
      ALU_SRL:  sc = SrcA >> sh;
      ALU_SUB:  sc = SrcA - SrcB;
      ALU_SRA:  sc = DATA_WIDTH'($signed(SrcA) >>> sh);
      ALU_EQ:   sc = DATA_WIDTH'(SrcA == SrcB);
      ALU_SLT:  sc = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      ALU_SLTU: sc = DATA_WIDTH'(SrcA < SrcB);
      default:  sc = '0;
    endcase
  end
  // next-state: IDLE accepts, CALC waits for the iterative unit, DONE waits for out_ready
  always_comb begin
    next = state;
    next = state == IDLE ? (accept ? (is_iter ? CALC : DONE) : IDLE) :
           state == CALC ? (it_done ? DONE : CALC) :
           (out_ready ? IDLE : DONE);
  end
  // state and result registers; result is written only when entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ALUResult <= '0;
    end else begin
      state <= next;
      if (accept && !is_iter) ALUResult <= sc;
      else if (state == CALC && it_done) ALUResult <= it_result;
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: table-driven check of multicycle_alu plus hold, ignore and reset-abort sequences (ALU_MULDIV_EN aware)
module tb_multicycle_alu;
  import alu_pkg::*;
  localparam int DW = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int ILAT = MD ? DW + 1 : 1;
  logic clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] SrcA, SrcB, ALUResult;
  logic [3:0] Operation;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input int lat, input string nm);
    int n;
    bit low;
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    chk({nm, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; SrcA = ~a; SrcB = ~b; Operation = ALU_OR;
    n = 1; low = 1'b1;
    while (!out_valid && n < 200) begin
      low &= !in_ready;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " result"}, ALUResult, y);
    if (lat > 1) chk({nm, " busy_in_ready_low"}, low, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid_cleared"}, out_valid, 0);
  endtask

  initial begin
    int cnt;
    v.push_back('{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    v.push_back('{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
    v.push_back('{ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1});
    v.push_back('{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1});
    v.push_back('{ALU_SLL,  32'h00000001, 32'h00000024, 32'h00000010, 1});
    v.push_back('{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1});
    v.push_back('{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1});
    v.push_back('{ALU_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1});
    v.push_back('{ALU_SRA,  32'h40000000, 32'h0000001E, 32'h00000001, 1});
    v.push_back('{ALU_EQ,   32'h00000005, 32'h00000005, 32'h00000001, 1});
    v.push_back('{ALU_EQ,   32'h00000005, 32'h00000006, 32'h00000000, 1});
    v.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    v.push_back('{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    v.push_back('{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1});
    v.push_back('{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1});
    v.push_back('{4'b1110,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1});
    v.push_back('{4'b1111,  32'h12345678, 32'h00000001, 32'h00000000, 1});
    v.push_back('{ALU_MUL,  32'h00010003, 32'h00020005, MD ? 32'h000B000F : 32'h0, ILAT});
    v.push_back('{ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'h00000001 : 32'h0, ILAT});
    v.push_back('{ALU_DIVU, 32'd100,      32'd0,        MD ? 32'hFFFFFFFF : 32'h0, ILAT});
    v.push_back('{ALU_REMU, 32'd100,      32'd0,        MD ? 32'd100      : 32'h0, ILAT});
    v.push_back('{ALU_DIVU, 32'd100,      32'd7,        MD ? 32'd14       : 32'h0, ILAT});
    v.push_back('{ALU_REMU, 32'd100,      32'd7,        MD ? 32'd2        : 32'h0, ILAT});
    v.push_back('{ALU_DIVU, 32'hFFFFFFFF, 32'h00000010, MD ? 32'h0FFFFFFF : 32'h0, ILAT});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset ALUResult", ALUResult, 0);
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("post_reset in_ready", in_ready, 1);

    foreach (v[i]) run_op(v[i].op, v[i].a, v[i].b, v[i].y, v[i].lat, $sformatf("vec%0d", i));

    @(negedge clk);
    Operation = ALU_ADD; SrcA = 32'd7; SrcB = 32'd8; in_valid = 1'b1;
    @(negedge clk);
    SrcA = 32'd100; SrcB = 32'd200;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d out_valid", i), out_valid, 1);
      chk($sformatf("hold%0d ALUResult", i), ALUResult, 15);
      chk($sformatf("hold%0d in_ready", i), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("hold release in_ready", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("after release out_valid", out_valid, 0);
    chk("after release in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("next op out_valid", out_valid, 1);
    chk("next op ALUResult", ALUResult, 300);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    @(negedge clk);
    Operation = ALU_DIVU; SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort ALUResult", ALUResult, 0);
    chk("abort in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort release in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(out_valid);
    end
    chk("abort no result", cnt, 0);
    run_op(ALU_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
